// File: rtl/hazard_pkg.sv
// Shared types and constants for the forwarding/hazard unit and its stage tracker.
// Latency: not applicable (types and constants only).
// Backpressure: not applicable.
package hazard_pkg;

    localparam int         SEL_W  = 3;
    localparam logic [4:0] REG_X0 = 5'd0;

    // One in-flight instruction as seen by the forwarding search
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       is_load;
    } stage_rec_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Decode-side request and hazard-unit response bundle.
// Latency: wires only; the unit answers combinationally in the same cycle.
// Backpressure: the stall output holds decode; there is no ready/valid pair.
interface fwd_hazard_unit_if #(
    parameter int NUM_STAGES = 2,
    parameter int CNT_W      = 32
);
    import hazard_pkg::*;

    logic                  dec_valid;
    logic [4:0]            dec_rs1;
    logic [4:0]            dec_rs2;
    logic                  dec_use_rs1;
    logic                  dec_use_rs2;
    logic [4:0]            dec_rd;
    logic                  dec_wr;
    logic                  dec_is_load;
    logic                  redirect;
    logic                  cnt_clr;

    logic [SEL_W-1:0]      fwd_rs1_sel;
    logic [SEL_W-1:0]      fwd_rs2_sel;
    logic                  stall;
    logic [NUM_STAGES-1:0] stage_valid;
    logic [CNT_W-1:0]      stall_count;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
               dec_rd, dec_wr, dec_is_load, redirect, cnt_clr,
        input  fwd_rs1_sel, fwd_rs2_sel, stall, stage_valid,
               stall_count, flush_count
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
               dec_rd, dec_wr, dec_is_load, redirect, cnt_clr,
        output fwd_rs1_sel, fwd_rs2_sel, stall, stage_valid,
               stall_count, flush_count
    );

endinterface

// File: rtl/hazard_stage_pipe.sv
// Shift register of in-flight instruction records; index 0 is stage 1 (EX).
// Latency: one cycle per stage; stage 1 takes a bubble when load is low.
// Backpressure: none; downstream stages always advance.
module hazard_stage_pipe
    import hazard_pkg::*;
#(
    parameter int NUM_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  stage_rec_t                  in_rec,
    output stage_rec_t [NUM_STAGES-1:0] stages
);

    // Shift every cycle; stage 1 takes either the decode record or a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages[0] <= load ? in_rec : '0;
            for (int k = 1; k < NUM_STAGES; k++) begin
                stages[k] <= stages[k-1];
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Per-operand youngest-source forwarding select, load-use stall, redirect squash, perf counters.
// Latency: selects and stall are combinational from stage state and decode inputs.
// Backpressure: stall holds PC/decode and inserts a bubble into stage 1; redirect overrides stall.
module fwd_hazard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int LOAD_LAT   = 2,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    fwd_hazard_unit_if.slave   bus
);

    stage_rec_t [NUM_STAGES-1:0] stages;
    stage_rec_t                  dec_rec;
    logic                        stall;
    logic                        load_s1;
    logic [CNT_W-1:0]            stall_cnt;
    logic [CNT_W-1:0]            flush_cnt;

    assign dec_rec = '{valid: 1'b1, rd: bus.dec_rd, wr: bus.dec_wr, is_load: bus.dec_is_load};

    for (genvar g = 0; g < 2; g++) begin : g_op
        logic [4:0]       addr;
        logic             use_op;
        logic [SEL_W-1:0] sel;
        logic             haz;

        assign addr   = (g == 0) ? bus.dec_rs1 : bus.dec_rs2;
        assign use_op = (g == 0) ? bus.dec_use_rs1 : bus.dec_use_rs2;

        // Scan oldest to youngest so the smallest matching stage index wins
        always_comb begin
            sel = '0;
            haz = 1'b0;
            if (use_op && addr != REG_X0) begin
                for (int k = NUM_STAGES; k >= 1; k--) begin
                    if (stages[k-1].valid && stages[k-1].wr && stages[k-1].rd == addr) begin
                        if (stages[k-1].is_load && k < LOAD_LAT) begin
                            sel = '0;
                            haz = 1'b1;
                        end else begin
                            sel = SEL_W'(k);
                            haz = 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign stall   = bus.dec_valid && (g_op[0].haz || g_op[1].haz) && !bus.redirect;
    assign load_s1 = bus.dec_valid && !stall && !bus.redirect;

    hazard_stage_pipe #(
        .NUM_STAGES (NUM_STAGES)
    ) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .load   (load_s1),
        .in_rec (dec_rec),
        .stages (stages)
    );

    // Collect per-stage valid bits for the pipeline view
    always_comb begin
        bus.stage_valid = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            bus.stage_valid[k] = stages[k].valid;
        end
    end

    // Saturating event counters; clear beats increment
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (bus.cnt_clr) begin
                stall_cnt <= '0;
            end else if (stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (bus.cnt_clr) begin
                flush_cnt <= '0;
            end else if (bus.redirect && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.fwd_rs1_sel = g_op[0].sel;
    assign bus.fwd_rs2_sel = g_op[1].sel;
    assign bus.stall       = stall;
    assign bus.stall_count = stall_cnt;
    assign bus.flush_count = flush_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for two configurations of the forwarding/hazard unit.
// Latency: expectations are checked on the falling edge of the same cycle they are driven.
// Backpressure: stall cycles are replayed by re-driving the same consumer.
module tb_fwd_hazard_unit;

    logic clk;
    logic rst;

    int n_cmp;
    int n_bad;

    typedef struct {
        string       tag;
        int          which;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic        st;
        logic [2:0]  sv;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t sb[$];

    fwd_hazard_unit_if #(.NUM_STAGES(2), .CNT_W(32)) u1 ();
    fwd_hazard_unit_if #(.NUM_STAGES(3), .CNT_W(3))  u2 ();

    fwd_hazard_unit #(.NUM_STAGES(2), .LOAD_LAT(2), .CNT_W(32)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (u1)
    );

    fwd_hazard_unit #(.NUM_STAGES(3), .LOAD_LAT(3), .CNT_W(3)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (u2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drv(input int which, input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic us1, input logic us2, input logic [4:0] rd, input logic wr,
                       input logic ld, input logic rdr, input logic clr);
        if (which == 1) begin
            u1.dec_valid = v;   u1.dec_rs1 = r1;  u1.dec_rs2 = r2;
            u1.dec_use_rs1 = us1; u1.dec_use_rs2 = us2;
            u1.dec_rd = rd;     u1.dec_wr = wr;   u1.dec_is_load = ld;
            u1.redirect = rdr;  u1.cnt_clr = clr;
        end else begin
            u2.dec_valid = v;   u2.dec_rs1 = r1;  u2.dec_rs2 = r2;
            u2.dec_use_rs1 = us1; u2.dec_use_rs2 = us2;
            u2.dec_rd = rd;     u2.dec_wr = wr;   u2.dec_is_load = ld;
            u2.redirect = rdr;  u2.cnt_clr = clr;
        end
    endtask

    // Push the expectation, sample on the falling edge, pop and compare, then advance a cycle
    task automatic step(input int which, input string tag, input logic [2:0] s1, input logic [2:0] s2,
                        input logic st, input logic [2:0] sv, input logic [31:0] sc, input logic [31:0] fc);
        exp_t e;
        e = '{tag: tag, which: which, s1: s1, s2: s2, st: st, sv: sv, sc: sc, fc: fc};
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        if (e.which == 1) begin
            chk({e.tag, ".sel1"},  32'(u1.fwd_rs1_sel), 32'(e.s1));
            chk({e.tag, ".sel2"},  32'(u1.fwd_rs2_sel), 32'(e.s2));
            chk({e.tag, ".stall"}, 32'(u1.stall),       32'(e.st));
            chk({e.tag, ".valid"}, 32'(u1.stage_valid), 32'(e.sv));
            chk({e.tag, ".scnt"},  u1.stall_count,      e.sc);
            chk({e.tag, ".fcnt"},  u1.flush_count,      e.fc);
        end else begin
            chk({e.tag, ".sel1"},  32'(u2.fwd_rs1_sel), 32'(e.s1));
            chk({e.tag, ".sel2"},  32'(u2.fwd_rs2_sel), 32'(e.s2));
            chk({e.tag, ".stall"}, 32'(u2.stall),       32'(e.st));
            chk({e.tag, ".valid"}, 32'(u2.stage_valid), 32'(e.sv));
            chk({e.tag, ".scnt"},  32'(u2.stall_count), e.sc);
            chk({e.tag, ".fcnt"},  32'(u2.flush_count), e.fc);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sat7(input int v);
        return (v > 7) ? 32'd7 : 32'(v);
    endfunction

    initial begin
        logic [2:0] one;
        logic [2:0] sv_exp;
        int         base;
        n_cmp = 0;
        n_bad = 0;
        one   = 3'b001;

        rst = 1'b1;
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // ---------------- NUM_STAGES=2, LOAD_LAT=2 ----------------
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, "reset", 0, 0, 0, 3'b000, 0, 0);

        drv(1, 1, 1, 2, 1, 1, 5, 1, 0, 0, 0);      // ADD x5
        step(1, "add_x5", 0, 0, 0, 3'b000, 0, 0);
        drv(1, 1, 5, 0, 1, 1, 6, 1, 0, 0, 0);      // ADD x6,x5,x0
        step(1, "fwd_s1", 1, 0, 0, 3'b001, 0, 0);
        drv(1, 1, 6, 5, 1, 0, 5, 1, 0, 0, 0);      // ADDI x5,x6 (rs2 not read)
        step(1, "use0", 1, 0, 0, 3'b011, 0, 0);
        drv(1, 1, 5, 5, 1, 1, 5, 1, 0, 0, 0);      // ADD x5,x5,x5
        step(1, "fwd_both", 1, 1, 0, 3'b011, 0, 0);
        drv(1, 1, 5, 5, 1, 1, 10, 1, 0, 0, 0);     // x5 in stages 1 and 2
        step(1, "youngest", 1, 1, 0, 3'b011, 0, 0);
        drv(1, 1, 5, 10, 1, 1, 11, 1, 0, 0, 0);
        step(1, "fwd_s2", 2, 1, 0, 3'b011, 0, 0);

        drv(1, 1, 1, 0, 1, 0, 7, 1, 1, 0, 0);      // LW x7
        step(1, "lw_x7", 0, 0, 0, 3'b011, 0, 0);
        drv(1, 1, 7, 7, 1, 1, 8, 1, 0, 0, 0);      // ADD x8,x7,x7
        step(1, "ld_use", 0, 0, 1, 3'b011, 0, 0);
        step(1, "ld_fwd", 2, 2, 0, 3'b010, 1, 0);

        drv(1, 1, 8, 0, 1, 0, 0, 1, 0, 0, 0);      // ADDI x0,x8
        step(1, "addi_x0", 1, 0, 0, 3'b001, 1, 0);
        drv(1, 1, 0, 0, 1, 1, 9, 1, 0, 0, 0);      // ADD x9,x0,x0
        step(1, "x0_src", 0, 0, 0, 3'b011, 1, 0);
        drv(1, 1, 1, 9, 1, 1, 9, 0, 0, 0, 0);      // STORE rs2=x9
        step(1, "st_use1", 0, 1, 0, 3'b011, 1, 0);
        drv(1, 1, 1, 9, 1, 0, 9, 0, 0, 0, 0);
        step(1, "st_use0", 0, 0, 0, 3'b011, 1, 0);
        drv(1, 1, 1, 9, 1, 1, 12, 1, 0, 0, 0);     // rd9 only in non-writing stages
        step(1, "wr0_src", 0, 0, 0, 3'b011, 1, 0);

        drv(1, 1, 1, 0, 1, 0, 13, 1, 1, 0, 0);     // LW x13
        step(1, "lw_x13", 0, 0, 0, 3'b011, 1, 0);
        drv(1, 1, 13, 13, 1, 1, 14, 1, 0, 1, 0);   // load-use plus redirect
        step(1, "redir_haz", 0, 0, 0, 3'b011, 1, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, "redir_bub", 0, 0, 0, 3'b010, 1, 1);

        for (int i = 0; i < 4; i++) begin
            drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            step(1, "flush_cnt", 0, 0, 0, 3'b000, 1, 32'(1 + i));
        end
        drv(1, 1, 0, 0, 0, 0, 20, 1, 0, 0, 0);
        step(1, "fill_a", 0, 0, 0, 3'b000, 1, 5);
        drv(1, 1, 0, 0, 0, 0, 21, 1, 0, 0, 0);
        step(1, "fill_b", 0, 0, 0, 3'b001, 1, 5);
        drv(1, 1, 21, 20, 1, 1, 22, 1, 0, 0, 0);
        rst = 1'b1;
        step(1, "pre_rst", 1, 2, 0, 3'b011, 1, 5);
        rst = 1'b0;
        step(1, "post_rst", 0, 0, 0, 3'b000, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ---------------- NUM_STAGES=3, LOAD_LAT=3, CNT_W=3 ----------------
        for (int r = 0; r < 4; r++) begin
            base = 2 * r;
            drv(2, 1, 0, 0, 1, 1, 7, 1, 1, 0, 0);  // LW x7
            step(2, "l3_lw", 0, 0, 0, (r == 0) ? 3'b000 : 3'b001, sat7(base), 0);
            drv(2, 1, 7, 0, 1, 1, 8, 1, 0, 0, 0);  // ADD x8,x7,x0
            step(2, "l3_st1", 0, 0, 1, (r == 0) ? 3'b001 : 3'b011, sat7(base), 0);
            step(2, "l3_st2", 0, 0, 1, (r == 0) ? 3'b010 : 3'b110, sat7(base + 1), 0);
            step(2, "l3_fwd", 3, 0, 0, 3'b100, sat7(base + 2), 0);
        end

        drv(2, 1, 0, 0, 1, 1, 7, 1, 1, 0, 0);
        step(2, "clr_lw", 0, 0, 0, 3'b001, 7, 0);
        drv(2, 1, 7, 0, 1, 1, 8, 1, 0, 0, 1);      // clear during a stall at saturation
        step(2, "clr_st", 0, 0, 1, 3'b011, 7, 0);
        drv(2, 1, 7, 0, 1, 1, 8, 1, 0, 0, 0);
        step(2, "clr_done", 0, 0, 1, 3'b110, 0, 0);
        step(2, "clr_inc", 3, 0, 0, 3'b100, 1, 0);

        for (int i = 0; i < 9; i++) begin
            drv(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            sv_exp = (i < 3) ? (one << i) : 3'b000;
            step(2, "fsat", 0, 0, 0, sv_exp, 1, sat7(i));
        end
        drv(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);      // clear beats the redirect increment
        step(2, "fclr", 0, 0, 0, 3'b000, 1, 7);
        drv(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(2, "fclr_done", 0, 0, 0, 3'b000, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the RISC-V core pipeline. It sits beside decode and replaces the opcode-specific, fixed-depth forwarding equations with a generic rd-tracking scoreboard. It tracks the destination of every in-flight instruction after decode and selects the youngest forwarding source per operand. It stalls decode on load-use hazards, squashes on redirect, and keeps stall/flush performance counters.

## Interface
- NUM_STAGES, 2, in-flight stages tracked after decode; stage 1 = EX, stage NUM_STAGES = writeback; range 1..6
- LOAD_LAT, 2, first stage index at which load data is forwardable; range 1..NUM_STAGES
- CNT_W, 32, width of performance counters
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- dec_valid  in  1  decode holds a real instruction
- dec_rs1, dec_rs2  in  5  source register addresses
- dec_use_rs1, dec_use_rs2  in  1  operand actually read (0 for LUI/AUIPC/JAL rs1; 0 for I/LOAD/JALR rs2)
- dec_rd  in  5  destination register
- dec_wr  in  1  instruction writes rd (0 for BRANCH/STORE/CSRW)
- dec_is_load  in  1  instruction is a load
- redirect  in  1  taken branch/jump resolved in stage 1
- cnt_clr  in  1  synchronous clear of both counters
- fwd_rs1_sel, fwd_rs2_sel  out  3  0 = register file, k = forward from stage k
- stall  out  1  hold PC and decode; bubble into stage 1
- stage_valid  out  NUM_STAGES  per-stage valid bits
- stall_count, flush_count  out  CNT_W  saturating event counters

## Operation
- Each tracked stage k holds the record {valid, rd, wr, is_load}. A stage with rd==0 or wr==0 is never a forwarding source.
- Operand search, per operand with use=1 and addr!=0: find the smallest k with valid && wr && rd==addr.
  - No match: sel=0.
  - Match, and stage k is a load with k<LOAD_LAT: hazard; sel=0.
  - Match otherwise: sel=k.
  - An operand with use=0 gives sel=0 and no hazard.
- stall = dec_valid && (hazard_rs1 || hazard_rs2) && !redirect.
- Stage 1 update:
  - Loads the decode record when dec_valid && !stall && !redirect.
  - Otherwise loads a bubble (valid=0).
  - Stages 2..NUM_STAGES shift from k-1 every cycle, with no stall of downstream stages.
- redirect and stall together: redirect wins. stall=0, stage 1 gets a bubble, flush_count increments, stall_count does not.
- stall_count increments each cycle stall=1. flush_count increments each cycle redirect=1.
- Both counters saturate at all-ones. cnt_clr has priority over increment.

## Timing
- fwd_*_sel and stall are combinational from the registered stage state and current decode inputs, so there is zero added latency.
- Stage records and counters update on posedge clk.
- Reset: every stage valid=0, counters 0. As a result sel=0, stall=0 and stage_valid=0 in the first cycle after reset.
- Reset mid-operation discards all in-flight records. No forwarding from pre-reset instructions.
- Load-use with LOAD_LAT=L: a consumer directly behind a load stalls L-1 cycles. It then proceeds with sel=L.
- Writeback-stage forwarding (k=NUM_STAGES) covers the register-file write/read collision. No separate write-through is required.

## Structure
- Shared package hazard_pkg:
  - stage_rec_t typedef {valid, rd[4:0], wr, is_load}
  - SEL_W=3 constant
  - REG_X0=5'd0 constant
- One sub-module, hazard_stage_pipe: the parametrised shift register of stage_rec_t with bubble insertion and reset.
- Top-level fwd_hazard_unit holds:
  - the priority search, generated per operand
  - the stall/flush logic
  - the counters

## Test plan
- NUM_STAGES=2: ADD x5 then ADD x6,x5,x0 next cycle -> fwd_rs1_sel=1, fwd_rs2_sel=0, stall=0.
- x5 written in stage 2 and stage 1 simultaneously, consumer reads x5 -> sel=1 (youngest wins). Next cycle, with stage 1 holding an unrelated rd -> sel=2.
- LOAD_LAT=2: LW x7 then ADD x8,x7,x7 -> stall=1 for one cycle, stage_valid[0]=0 next cycle, then both sels=2. stall_count=1.
- ADDI x0 followed by ADD x9,x0,x0 -> both sels=0. STORE with rs2 matching -> sel only when dec_use_rs2=1.
- Load-use hazard with redirect in the same cycle -> stall=0, stage 1 bubble, flush_count=1, stall_count=0.
- rst asserted with all stages valid and counters at 5 -> next cycle stage_valid=0, counters 0, sels 0. cnt_clr with counter at all-ones and stall=1 -> 0.
